// File: rtl/board_input_conditioner_if.sv
// Raw board inputs and conditioned PIO-side outputs
// of the key/switch conditioner.
interface board_input_conditioner_if #(
  parameter int NUM_KEYS = 4,
  parameter int NUM_SW   = 10
);
  logic [NUM_KEYS-1:0] key_n_raw;
  logic [NUM_SW-1:0]   sw_raw;
  logic [NUM_KEYS-1:0] key_pio_n;
  logic [NUM_SW-1:0]   sw_pio;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_SW-1:0]   sw_change;
  logic                warm_reset_req_n;

  modport master (
    output key_n_raw, sw_raw,
    input  key_pio_n, sw_pio, key_press,
    input  sw_change, warm_reset_req_n
  );

  modport slave (
    input  key_n_raw, sw_raw,
    output key_pio_n, sw_pio, key_press,
    output sw_change, warm_reset_req_n
  );
endinterface

// File: rtl/board_input_conditioner.sv
// Synchronise and debounce DE10 keys/switches, emit edge
// pulses and a long-press HPS warm-reset request.
module board_input_conditioner #(
  parameter int NUM_KEYS          = 4,
  parameter int NUM_SW            = 10,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LP_KEY            = 0,
  parameter int LONG_PRESS_CYCLES = 150000000,
  parameter int REQ_PULSE_CYCLES  = 64
) (
  input  logic clk,
  input  logic reset,
  board_input_conditioner_if.slave io
);

  localparam int N  = NUM_KEYS + NUM_SW;
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LMAX =
    (LONG_PRESS_CYCLES > REQ_PULSE_CYCLES) ?
    LONG_PRESS_CYCLES : REQ_PULSE_CYCLES;
  localparam int LW = $clog2(LMAX);

  localparam logic [N-1:0] RST_VAL =
    {{NUM_SW{1'b0}}, {NUM_KEYS{1'b1}}};
  // switches pulse on any edge, keys only on press
  localparam logic [N-1:0] ANY_EDGE =
    {{NUM_SW{1'b1}}, {NUM_KEYS{1'b0}}};

  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LP_LAST =
    LW'(LONG_PRESS_CYCLES - 1);
  localparam logic [LW-1:0] REQ_LAST =
    LW'(REQ_PULSE_CYCLES - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] COUNT    = 2'd1;
  localparam logic [1:0] ASSERT   = 2'd2;
  localparam logic [1:0] WAIT_REL = 2'd3;

  logic [N-1:0]  raw;
  logic [N-1:0]  s1;
  logic [N-1:0]  sync;
  logic [N-1:0]  stable;
  logic [N-1:0]  pulse;
  logic [DW-1:0] cnt [N];

  logic [1:0]    state;
  logic [LW-1:0] lcnt;
  logic          req_n;
  logic          lp_key;

  assign raw = {io.sw_raw, io.key_n_raw};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= RST_VAL;
      sync <= RST_VAL;
    end else begin
      s1   <= raw;
      sync <= s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= RST_VAL;
      pulse  <= '0;
      for (int i = 0; i < N; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        pulse[i] <= 1'b0;
        if (sync[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != DB_LAST) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else begin
          stable[i] <= sync[i];
          cnt[i]    <= '0;
          pulse[i]  <= ANY_EDGE[i] | ~sync[i];
        end
      end
    end
  end

  assign lp_key = stable[LP_KEY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      lcnt  <= '0;
      req_n <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (!lp_key) begin
            state <= COUNT;
            lcnt  <= '0;
          end
        end
        COUNT: begin
          if (lp_key) begin
            state <= IDLE;
          end else if (lcnt == LP_LAST) begin
            state <= ASSERT;
            lcnt  <= '0;
            req_n <= 1'b0;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
        // pulse runs its full width even if the key is let go
        ASSERT: begin
          if (lcnt == REQ_LAST) begin
            state <= WAIT_REL;
            req_n <= 1'b1;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
        WAIT_REL: begin
          if (lp_key)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.key_pio_n        = stable[NUM_KEYS-1:0];
  assign io.sw_pio           = stable[N-1:NUM_KEYS];
  assign io.key_press        = pulse[NUM_KEYS-1:0];
  assign io.sw_change        = pulse[N-1:NUM_KEYS];
  assign io.warm_reset_req_n = req_n;

endmodule
